// File: rtl/cond_flag_if.sv
// ALU-flag / condition-query bundle between producer (master) and cond_flag_unit (slave).
interface cond_flag_if #(parameter int CNT_W = 16);
   logic [3:0]       flag_in;
   logic [6:0]       alu_sel;
   logic             flag_we;
   logic             req_valid;
   logic [3:0]       req_cond;
   logic             req_ready;
   logic             resp_valid;
   logic             resp_taken;
   logic             resp_ready;
   logic [3:0]       flags;
   logic [CNT_W-1:0] taken_count;
   logic             save_req;
   logic             restore_req;

   modport master (
      output flag_in, alu_sel, flag_we, req_valid, req_cond, resp_ready, save_req, restore_req,
      input  req_ready, resp_valid, resp_taken, flags, taken_count
   );

   modport slave (
      input  flag_in, alu_sel, flag_we, req_valid, req_cond, resp_ready, save_req, restore_req,
      output req_ready, resp_valid, resp_taken, flags, taken_count
   );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural ZNCV flag register with ARM condition-code query handshake.
// Optional shadow save/restore of the flags is enabled by defining FLAG_SAVE_EN.
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input logic         clk,
   input logic         reset,
   cond_flag_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [3:0]       flags_q, written_flags, eff_flags;
   logic             resp_taken_q, resp_taken_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Logical ops leave the ALU's C/V outputs at zero, so those bits are preserved.
   function automatic logic [3:0] apply_write(logic [3:0] old, logic [3:0] fin, logic [6:0] sel);
      case (sel)
         7'b1000000, 7'b0100000, 7'b0010000: apply_write = fin;
         7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001: apply_write = {fin[3:2], old[1:0]};
         default: apply_write = old;
      endcase
   endfunction

   function automatic logic eval_cond(logic [3:0] cond, logic [3:0] f);
      logic z, n, c, v;
      {z, n, c, v} = f;
      case (cond)
         4'd0:    eval_cond = z;
         4'd1:    eval_cond = !z;
         4'd2:    eval_cond = c;
         4'd3:    eval_cond = !c;
         4'd4:    eval_cond = n;
         4'd5:    eval_cond = !n;
         4'd6:    eval_cond = v;
         4'd7:    eval_cond = !v;
         4'd8:    eval_cond = c & !z;
         4'd9:    eval_cond = !c | z;
         4'd10:   eval_cond = (n == v);
         4'd11:   eval_cond = (n != v);
         4'd12:   eval_cond = !z & (n == v);
         4'd13:   eval_cond = z | (n != v);
         4'd14:   eval_cond = 1'b1;
         default: eval_cond = 1'b0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] x);
      sat_inc = (&x) ? x : x + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign written_flags = bus.flag_we ? apply_write(flags_q, bus.flag_in, bus.alu_sel) : flags_q;

`ifdef FLAG_SAVE_EN
   logic [3:0] shadow_q;

   // Shadow always captures the pre-restore value, which makes save+restore a swap.
   assign eff_flags = bus.restore_req ? shadow_q : written_flags;

   always_ff @(posedge clk) begin
      if (reset)             shadow_q <= 4'b0000;
      else if (bus.save_req) shadow_q <= written_flags;
   end
`else
   logic unused_save_ctl;
   assign unused_save_ctl = bus.save_req ^ bus.restore_req;
   assign eff_flags       = written_flags;
`endif

   always_comb begin
      state_d      = state_q;
      resp_taken_d = resp_taken_q;
      count_d      = count_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               resp_taken_d = eval_cond(bus.req_cond, eff_flags);
               state_d      = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
               if (resp_taken_q) count_d = sat_inc(count_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         flags_q      <= 4'b0000;
         resp_taken_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         flags_q      <= eff_flags;
         resp_taken_q <= resp_taken_d;
         count_q      <= count_d;
      end
   end

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.resp_valid  = (state_q == RESP);
   assign bus.resp_taken  = resp_taken_q;
   assign bus.flags       = flags_q;
   assign bus.taken_count = count_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed and randomized bench for cond_flag_unit against a spec-level flag/condition model.
module tb_cond_flag_unit;
   localparam int CW = 3;
   localparam logic [6:0] S_ADD = 7'b1000000, S_SUB = 7'b0100000, S_CMP = 7'b0010000,
                          S_AND = 7'b0001000, S_ORR = 7'b0000100, S_EOR = 7'b0000010,
                          S_MOV = 7'b0000001;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   // reference model state
   logic [3:0]    m_flags = 4'b0000;
   logic [3:0]    m_shadow = 4'b0000;
   bit            m_pending = 0;
   logic          m_taken = 1'b0;
   int unsigned   m_count = 0;

   cond_flag_if #(.CNT_W(CW)) bus ();

   cond_flag_unit #(.CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
      bit z, n, c, v;
      z = f[3]; n = f[2]; c = f[1]; v = f[0];
      case (int'(cond))
         0: return z;          1: return !z;
         2: return c;          3: return !c;
         4: return n;          5: return !n;
         6: return v;          7: return !v;
         8: return c && !z;    9: return !c || z;
         10: return n == v;    11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One clock: drive inputs, advance the model, then compare every output.
   task automatic cyc(input string tag, input logic rst_i, input logic we, input logic [6:0] sel,
                      input logic [3:0] fin, input logic rv, input logic [3:0] cond,
                      input logic rr, input logic sv, input logic rs);
      logic [3:0] wr, eff;
      @(negedge clk);
      reset           = rst_i;
      bus.flag_we     = we;
      bus.alu_sel     = sel;
      bus.flag_in     = fin;
      bus.req_valid   = rv;
      bus.req_cond    = cond;
      bus.resp_ready  = rr;
      bus.save_req    = sv;
      bus.restore_req = rs;
      if (rst_i) begin
         m_flags = 4'b0000; m_shadow = 4'b0000; m_pending = 0; m_taken = 1'b0; m_count = 0;
      end else begin
         wr = m_flags;
         if (we && (sel inside {S_ADD, S_SUB, S_CMP})) wr = fin;
         else if (we && (sel inside {S_AND, S_ORR, S_EOR, S_MOV})) wr = {fin[3:2], m_flags[1:0]};
         eff = wr;
`ifdef FLAG_SAVE_EN
         if (rs) eff = m_shadow;
         if (sv) m_shadow = wr;
`endif
         if (!m_pending) begin
            if (rv) begin
               m_taken   = cond_true(cond, eff);
               m_pending = 1;
            end
         end else if (rr) begin
            if (m_taken && m_count < (2**CW - 1)) m_count++;
            m_pending = 0;
         end
         m_flags = eff;
      end
      @(posedge clk);
      #1;
      chk({tag, ".flags"}, bus.flags, m_flags);
      chk({tag, ".resp_valid"}, bus.resp_valid, m_pending);
      chk({tag, ".resp_taken"}, bus.resp_taken, m_taken);
      chk({tag, ".req_ready"}, bus.req_ready, !m_pending);
      chk({tag, ".taken_count"}, bus.taken_count, m_count);
   endtask

   task automatic wr_flags(input string tag, input logic [6:0] sel, input logic [3:0] fin);
      cyc(tag, 0, 1, sel, fin, 0, 4'd0, 0, 0, 0);
   endtask

   initial begin
      logic [3:0]  conds [6];
      logic        exp_t [6];
      logic [6:0]  sels  [9];
      conds = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
      exp_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      sels  = '{S_ADD, S_SUB, S_CMP, S_AND, S_ORR, S_EOR, S_MOV, 7'b0000000, 7'b0110000};

      bus.flag_we = 0; bus.alu_sel = '0; bus.flag_in = '0; bus.req_valid = 0;
      bus.req_cond = '0; bus.resp_ready = 0; bus.save_req = 0; bus.restore_req = 0;

      // reset and basic write
      cyc("rst0", 1, 0, '0, '0, 0, '0, 0, 0, 0);
      cyc("rst1", 1, 0, '0, '0, 0, '0, 0, 0, 0);
      cyc("idle", 0, 0, '0, '0, 0, '0, 0, 0, 0);
      chk("req_ready_after_reset", bus.req_ready, 1'b1);
      wr_flags("sub1010", S_SUB, 4'b1010);
      chk("flags_sub", bus.flags, 4'b1010);

      // reset in the middle of a transaction drops the response
      cyc("req_pre_rst", 0, 0, '0, '0, 1, 4'd14, 0, 0, 0);
      chk("resp_valid_pending", bus.resp_valid, 1'b1);
      cyc("rst_mid", 1, 0, '0, '0, 0, '0, 0, 0, 0);
      chk("flags_after_rst", bus.flags, 4'b0000);
      chk("resp_valid_after_rst", bus.resp_valid, 1'b0);

      // C/V preservation and invalid selects
      wr_flags("add0011", S_ADD, 4'b0011);
      wr_flags("and0100", S_AND, 4'b0100);
      chk("flags_and_keep_cv", bus.flags, 4'b0111);
      wr_flags("sel_zero", 7'b0000000, 4'b1000);
      chk("flags_sel_zero", bus.flags, 4'b0111);
      wr_flags("sel_twohot", 7'b1100000, 4'b1000);
      chk("flags_sel_twohot", bus.flags, 4'b0111);

      // same-cycle CMP forwarded into the query
      cyc("cmp_eq", 0, 1, S_CMP, 4'b1000, 1, 4'd0, 0, 0, 0);
      chk("cmp_eq_valid", bus.resp_valid, 1'b1);
      chk("cmp_eq_taken", bus.resp_taken, 1'b1);
      cyc("cmp_eq_ack", 0, 0, '0, '0, 0, '0, 1, 0, 0);

      // signed conditions with N=1,V=0 and a 3-cycle hold each
      wr_flags("sub0100", S_SUB, 4'b0100);
      for (int i = 0; i < 6; i++) begin
         cyc("cond_req", 0, 0, '0, '0, 1, conds[i], 0, 0, 0);
         for (int h = 0; h < 3; h++) begin
            cyc("cond_hold", 0, 0, '0, '0, 1, 4'd14, 0, 0, 0);
            chk("cond_hold_valid", bus.resp_valid, 1'b1);
            chk("cond_hold_taken", bus.resp_taken, exp_t[i]);
            chk("cond_hold_ready", bus.req_ready, 1'b0);
         end
         cyc("cond_ack", 0, 0, '0, '0, 0, '0, 1, 0, 0);
      end

      // flag write while a response is held must not alter it
      cyc("ge_req", 0, 0, '0, '0, 1, 4'd10, 0, 0, 0);
      cyc("ge_hold_wr", 0, 1, S_SUB, 4'b0000, 0, '0, 0, 0, 0);
      chk("held_taken_after_wr", bus.resp_taken, 1'b0);
      chk("flags_wr_in_resp", bus.flags, 4'b0000);
      cyc("ge_ack", 0, 0, '0, '0, 0, '0, 1, 0, 0);

`ifdef FLAG_SAVE_EN
      wr_flags("sv_set", S_SUB, 4'b1001);
      cyc("save", 0, 0, '0, '0, 0, '0, 0, 1, 0);
      wr_flags("sv_add", S_ADD, 4'b0100);
      cyc("restore", 0, 0, '0, '0, 0, '0, 0, 0, 1);
      chk("flags_restored", bus.flags, 4'b1001);
      wr_flags("sw_a", S_SUB, 4'b0110);
      cyc("sw_save", 0, 0, '0, '0, 0, '0, 0, 1, 0);
      wr_flags("sw_b", S_SUB, 4'b1001);
      cyc("swap", 0, 0, '0, '0, 0, '0, 0, 1, 1);
      chk("flags_swapped", bus.flags, 4'b0110);
      cyc("swap_back", 0, 1, S_SUB, 4'b0000, 1, 4'd0, 0, 0, 1);
      chk("flags_swap_back", bus.flags, 4'b1001);
      chk("restore_fwd_taken", bus.resp_taken, 1'b1);
      cyc("swap_ack", 0, 0, '0, '0, 0, '0, 1, 0, 0);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc("rand", ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
             sels[$urandom_range(0, 8)], 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end

      // counter saturation, not-taken responses leave it alone
      cyc("sat_rst", 1, 0, '0, '0, 0, '0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc("sat_req", 0, 0, '0, '0, 1, (i == 3) ? 4'd15 : 4'd14, 0, 0, 0);
         cyc("sat_ack", 0, 0, '0, '0, 0, '0, 1, 0, 0);
         if (i == 3) chk("count_nv_unchanged", bus.taken_count, 3'd3);
      end
      chk("count_saturated", bus.taken_count, 3'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
